keycode_event_scheduler: RTL



---
 rtl/keycode_event_scheduler_if.sv | 23 ++
 rtl/keycode_event_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/keycode_event_scheduler_if.sv
// Avalon-MM register bus and event stream bundle for keycode_event_scheduler.
// The master side is the NIOS/consumer; the slave side is the scheduler.
interface keycode_event_scheduler_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        evt_valid;
    logic        evt_ready;
    logic [9:0]  evt_data;

    modport master (
        output address, chipselect, read_n, write_n, writedata, evt_ready,
        input  readdata, evt_valid, evt_data
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata, evt_ready,
        output readdata, evt_valid, evt_data
    );
endinterface

// File: rtl/keycode_event_scheduler.sv
// Converts keycode level changes into press/release/repeat events buffered in a FIFO.
// Optional input debouncing is enabled by defining KEYCODE_DEBOUNCE_EN.
module keycode_event_scheduler #(
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 26,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    keycode_in,
    keycode_event_scheduler_if.slave      bus
);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, PRESS_PEND} state_t;

    state_t             state, state_next;
    logic [7:0]         code_q, trk, trk_next;
    logic [1:0]         ctrl;
    logic [CNT_W-1:0]   delay_r, rate_r, rpt_cnt;
    logic [CNT_W-1:0]   delay_eff, rate_eff, rpt_target;
    logic               rpt_phase, overflow;
    logic               push, pop, push_ok, full;
    logic               cnt_clear, cnt_inc, cnt_wrap;
    logic [9:0]         push_data;
    logic [9:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               wr_en, enable, repeat_en;
    logic               unused_bits;

    assign unused_bits = &{1'b0, bus.read_n, bus.writedata};

`ifdef KEYCODE_DEBOUNCE_EN
    localparam int SCW = $clog2(DEBOUNCE_CYC + 1);
    logic [7:0]     raw_q;
    logic [SCW-1:0] stable_cnt;

    // code_q only moves once the raw input has held still long enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_q      <= '0;
            stable_cnt <= '0;
            code_q     <= '0;
        end else begin
            raw_q <= keycode_in;
            if (keycode_in != raw_q)
                stable_cnt <= '0;
            else if (stable_cnt < SCW'(DEBOUNCE_CYC - 1))
                stable_cnt <= stable_cnt + SCW'(1);
            else
                code_q <= raw_q;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) code_q <= '0;
        else          code_q <= keycode_in;
    end
`endif

    assign wr_en      = bus.chipselect && !bus.write_n;
    assign enable     = ctrl[0];
    assign repeat_en  = ctrl[1];
    assign delay_eff  = (delay_r == '0) ? CNT_W'(1) : delay_r;
    assign rate_eff   = (rate_r  == '0) ? CNT_W'(1) : rate_r;
    assign rpt_target = rpt_phase ? rate_eff : delay_eff;

    always_comb begin
        state_next = state;
        trk_next   = trk;
        push       = 1'b0;
        push_data  = '0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        cnt_wrap   = 1'b0;
        case (state)
            IDLE: begin
                if (code_q != trk) begin
                    trk_next  = code_q;
                    cnt_clear = 1'b1;
                    push      = enable;
                    if (trk != '0) begin
                        push_data = {2'b00, trk};
                        if (code_q != '0) state_next = PRESS_PEND;
                    end else begin
                        push_data = {2'b01, code_q};
                    end
                end else if (trk != '0 && enable && repeat_en) begin
                    if (rpt_cnt == rpt_target - CNT_W'(1)) begin
                        push      = 1'b1;
                        push_data = {2'b11, trk};
                        cnt_wrap  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            PRESS_PEND: begin
                push       = enable;
                push_data  = {2'b01, trk};
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            trk       <= '0;
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else begin
            state <= state_next;
            trk   <= trk_next;
            if (cnt_clear) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b0;
            end else if (cnt_wrap) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b1;
            end else if (cnt_inc) begin
                rpt_cnt <= rpt_cnt + CNT_W'(1);
            end
        end
    end

    // A push into a full FIFO still lands if the head is leaving the same cycle
    assign full          = (count == CW'(FIFO_DEPTH));
    assign bus.evt_valid = (count != '0);
    assign bus.evt_data  = mem[rd_ptr];
    assign pop           = bus.evt_valid && bus.evt_ready;
    assign push_ok       = push && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (!push_ok && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= 2'b11;
            delay_r  <= CNT_W'(25_000_000);
            rate_r   <= CNT_W'(5_000_000);
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                case (bus.address)
                    2'd0: ctrl    <= bus.writedata[1:0];
                    2'd1: delay_r <= bus.writedata[CNT_W-1:0];
                    2'd2: rate_r  <= bus.writedata[CNT_W-1:0];
                    2'd3: if (bus.writedata[0]) overflow <= 1'b0;
                    default: ;
                endcase
            end
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: bus.readdata[1:0] = ctrl;
            2'd1: bus.readdata      = 32'(delay_r);
            2'd2: bus.readdata      = 32'(rate_r);
            2'd3: begin
                bus.readdata[15:8] = 8'(count);
                bus.readdata[0]    = overflow;
            end
            default: ;
        endcase
    end
endmodule
